// File: rtl/data_access.sv
// -----------------------------------------------------------------------------
// data_access -- data-memory access stage of the RV32I core.
//
// Takes one load/store request per instruction, performs a single-beat AXI4
// read or write on the data port, aligns/extends load data and reports the
// result with a one-cycle RESULT_VALID pulse. MEM_WAIT stalls the core while
// a request is in flight.
//
// Ports
//   CLK, RSTN           clock, synchronous active-low reset
//   REQ_*               request from execute (held stable while MEM_WAIT=1)
//   MEM_WAIT            stall request to the core (combinational)
//   RESULT_*, ERR_*     registered result, valid while RESULT_VALID=1
//   DBG_STATE           current FSM state (debug/observability)
//   M_AXI_*             AXI4 master, single-beat 32-bit transfers only
//
// Handshake rule for every AXI channel: a transfer happens on a rising edge
// where VALID and READY are both high. VALID is driven purely from FSM state,
// never from READY, and ADDR/DATA/STRB are held stable while VALID is high.
// -----------------------------------------------------------------------------
module data_access #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  // request
  input  logic                               REQ_VALID,
  input  logic                               REQ_WRITE,
  input  logic [2:0]                         REQ_FUNCT3,
  input  logic [31:0]                        REQ_ADDR,
  input  logic [31:0]                        REQ_WDATA,
  input  logic [4:0]                         REQ_RD,
  // status / result
  output logic                               MEM_WAIT,
  output logic                               RESULT_VALID,
  output logic [4:0]                         RESULT_RD,
  output logic [31:0]                        RESULT_DATA,
  output logic                               ERR_MISALIGN,
  output logic                               ERR_BUS,
  output logic [2:0]                         DBG_STATE,
  // AXI write address
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [0:0]                         M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  // AXI write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [0:0]                         M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  // AXI write response
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [0:0]                         M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  // AXI read address
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [0:0]                         M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  // AXI read data
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [0:0]                         M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        result_valid_q, result_valid_d;
  logic [4:0]  result_rd_q, result_rd_d;
  logic [31:0] result_data_q, result_data_d;
  logic        err_misalign_q, err_misalign_d;
  logic        err_bus_q, err_bus_d;

  logic        req_legal;
  logic [31:0] store_data;
  logic [3:0]  store_strb;
  logic [31:0] rdata32;
  logic [31:0] rdata_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        aw_fire;
  logic        w_fire;

  // Illegal funct3 encodings are reported through the misalign flag, so they
  // are folded into the same legality check as the alignment rules.
  always_comb begin
    req_legal = 1'b0;
    case (REQ_FUNCT3)
      3'd0:    req_legal = 1'b1;
      3'd1:    req_legal = ~REQ_ADDR[0];
      3'd2:    req_legal = (REQ_ADDR[1:0] == 2'b00);
      3'd4:    req_legal = ~REQ_WRITE;
      3'd5:    req_legal = ~REQ_WRITE & ~REQ_ADDR[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Narrow stores are replicated across lanes so the strobe alone selects
  // which bytes the slave writes.
  always_comb begin
    store_data = REQ_WDATA;
    store_strb = 4'b1111;
    case (REQ_FUNCT3[1:0])
      2'd0: begin
        store_data = {4{REQ_WDATA[7:0]}};
        store_strb = 4'b0001 << REQ_ADDR[1:0];
      end
      2'd1: begin
        store_data = {2{REQ_WDATA[15:0]}};
        store_strb = 4'b0011 << {REQ_ADDR[1], 1'b0};
      end
      default: begin
        store_data = REQ_WDATA;
        store_strb = 4'b1111;
      end
    endcase
  end

  // Load alignment: shift the addressed byte lane down to bit 0.
  always_comb begin
    rdata32     = M_AXI_RDATA[31:0];
    rdata_shift = rdata32 >> {addr_q[1:0], 3'b000};
    ld_byte     = rdata_shift[7:0];
    ld_half     = addr_q[1] ? rdata32[31:16] : rdata32[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    load_ext = {24'd0, ld_byte};
      3'd1:    load_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    load_ext = {16'd0, ld_half};
      default: load_ext = rdata32;
    endcase
  end

  assign aw_fire = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID & M_AXI_WREADY;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    result_valid_d = 1'b0;
    result_rd_d    = result_rd_q;
    result_data_d  = result_data_q;
    err_misalign_d = err_misalign_q;
    err_bus_d      = err_bus_q;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (req_legal) begin
            addr_d    = REQ_ADDR;
            funct3_d  = REQ_FUNCT3;
            rd_d      = REQ_RD;
            wdata_d   = store_data;
            wstrb_d   = store_strb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = REQ_WRITE ? S_AW_W : S_AR;
          end else begin
            // Rejected without touching the bus.
            state_d        = S_DONE;
            result_valid_d = 1'b1;
            result_rd_d    = REQ_WRITE ? 5'd0 : REQ_RD;
            result_data_d  = 32'd0;
            err_misalign_d = 1'b1;
            err_bus_d      = 1'b0;
          end
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) state_d = S_R;
      end
      S_R: begin
        if (M_AXI_RVALID) begin
          state_d        = S_DONE;
          result_valid_d = 1'b1;
          result_rd_d    = rd_q;
          result_data_d  = (M_AXI_RRESP != 2'b00) ? 32'd0 : load_ext;
          err_misalign_d = 1'b0;
          err_bus_d      = (M_AXI_RRESP != 2'b00);
        end
      end
      S_AW_W: begin
        // AW and W complete independently; leave once both have, which may
        // be in the same cycle.
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_d = S_B;
      end
      S_B: begin
        if (M_AXI_BVALID) begin
          state_d        = S_DONE;
          result_valid_d = 1'b1;
          result_rd_d    = 5'd0;
          result_data_d  = 32'd0;
          err_misalign_d = 1'b0;
          err_bus_d      = (M_AXI_BRESP != 2'b00);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q        <= S_IDLE;
      addr_q         <= 32'd0;
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      wdata_q        <= 32'd0;
      wstrb_q        <= 4'd0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      result_valid_q <= 1'b0;
      result_rd_q    <= 5'd0;
      result_data_q  <= 32'd0;
      err_misalign_q <= 1'b0;
      err_bus_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      result_valid_q <= result_valid_d;
      result_rd_q    <= result_rd_d;
      result_data_q  <= result_data_d;
      err_misalign_q <= err_misalign_d;
      err_bus_q      <= err_bus_d;
    end
  end

  // Core side. MEM_WAIT drops in DONE so the core advances on the same cycle
  // the result pulse is presented.
  assign MEM_WAIT     = REQ_VALID & (state_q != S_DONE);
  assign RESULT_VALID = result_valid_q;
  assign RESULT_RD    = result_rd_q;
  assign RESULT_DATA  = result_data_q;
  assign ERR_MISALIGN = err_misalign_q;
  assign ERR_BUS      = err_bus_q;
  assign DBG_STATE    = state_q;

  // Write channels
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({addr_q[31:2], 2'b00});
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 1'b0;
  assign M_AXI_AWVALID = (state_q == S_AW_W) & ~aw_done_q;
  assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(wdata_q);
  assign M_AXI_WSTRB   = STRB_W'(wstrb_q);
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WUSER   = 1'b0;
  assign M_AXI_WVALID  = (state_q == S_AW_W) & ~w_done_q;
  assign M_AXI_BREADY  = (state_q == S_B);

  // Read channels
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({addr_q[31:2], 2'b00});
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = 1'b0;
  assign M_AXI_ARVALID = (state_q == S_AR);
  assign M_AXI_RREADY  = (state_q == S_R);

  // IDs, RLAST and USER fields carry no information for single-beat,
  // single-ID traffic.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST, M_AXI_BUSER, M_AXI_RUSER};

endmodule

// File: tb/tb_data_access.sv
// -----------------------------------------------------------------------------
// tb_data_access -- directed bench for data_access.
// A cycle-stepped AXI slave with per-channel wait counts answers the DUT;
// expected load results are queued in exp_q and popped on RESULT_VALID.
// -----------------------------------------------------------------------------
module tb_data_access;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;

  logic        mem_wait, result_valid, err_misalign, err_bus;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic [2:0]  dbg_state;

  logic [0:0]  awid, arid, awuser, aruser, wuser;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;

  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'd0;

  data_access dut (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_FUNCT3(req_funct3),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
    .MEM_WAIT(mem_wait), .RESULT_VALID(result_valid), .RESULT_RD(result_rd),
    .RESULT_DATA(result_data), .ERR_MISALIGN(err_misalign), .ERR_BUS(err_bus),
    .DBG_STATE(dbg_state),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WUSER(wuser), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(bresp), .M_AXI_BUSER(1'b0),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(1'b0), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(1'b1), .M_AXI_RUSER(1'b0), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // slave configuration
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] rdata_cfg = 32'd0;
  logic [1:0]  resp_cfg = 2'b00;

  // per-request observations
  int          res_cycle, ar_cycles, aw_cycles, w_cycles, rv_after_rst;
  logic [4:0]  res_rd;
  logic        res_mis, res_bus;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;
  logic        seen_wlast;
  logic [63:0] wait_mask;
  logic [5:0]  post_rst_bus;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request and play the slave until RESULT_VALID (or, with
  // rst_at >= 0, pulse reset in that cycle and watch the aftermath).
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int rst_at);
    int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, limit;
    bit  r_pend, b_pend, aw_ok, w_ok, b_started, done;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0; b_started = 0; done = 0;
    res_cycle = -1; ar_cycles = 0; aw_cycles = 0; w_cycles = 0; rv_after_rst = 0;
    wait_mask = '0; post_rst_bus = '1;
    limit = (rst_at >= 0) ? rst_at + 8 : 40;
    for (int c = 0; c < limit && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = rd;
      end
      if (rst_at >= 0) begin
        rstn = (c == rst_at) ? 1'b0 : 1'b1;
        if (c == rst_at) req_valid = 1'b0;
      end
      arready = arvalid && (ar_cnt >= ar_wait);
      rvalid  = r_pend && (r_cnt >= r_wait);
      rdata   = rdata_cfg;
      rresp   = resp_cfg;
      awready = awvalid && (aw_cnt >= aw_wait);
      wready  = wvalid && (w_cnt >= w_wait);
      bvalid  = b_pend && (b_cnt >= b_wait);
      bresp   = resp_cfg;
      #1;
      if (mem_wait && c < 64) wait_mask[c] = 1'b1;
      if (arvalid) begin ar_cycles++; seen_araddr = araddr; end
      if (awvalid) begin aw_cycles++; seen_awaddr = awaddr; end
      if (wvalid) begin
        w_cycles++; seen_wdata = wdata; seen_wstrb = wstrb; seen_wlast = wlast;
      end
      if (rst_at >= 0 && c == rst_at + 1)
        post_rst_bus = {arvalid, rready, awvalid, wvalid, bready, result_valid};
      if (rst_at >= 0 && c > rst_at && result_valid) rv_after_rst++;
      if (rst_at < 0 && result_valid) begin
        res_cycle = c; res_rd = result_rd; res_mis = err_misalign; res_bus = err_bus;
        if (exp_q.size() != 0) check({tag, "_data"}, result_data, exp_q.pop_front());
        done = 1;
        req_valid = 1'b0;
      end
      // slave bookkeeping at the coming edge
      if (r_pend) begin
        if (rvalid && rready) r_pend = 0; else r_cnt++;
      end
      if (arvalid && arready) begin r_pend = 1; r_cnt = 0; end
      else if (arvalid) ar_cnt++;
      if (awvalid && awready) aw_ok = 1; else if (awvalid) aw_cnt++;
      if (wvalid && wready) w_ok = 1; else if (wvalid) w_cnt++;
      if (b_pend) begin
        if (bvalid && bready) b_pend = 0; else b_cnt++;
      end
      if (!b_started && aw_ok && w_ok) begin b_pend = 1; b_cnt = 0; b_started = 1; end
      if (rst_at >= 0 && c == rst_at) begin r_pend = 0; b_pend = 0; end
    end
    req_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input int cyc, input logic [4:0] rd,
                            input logic mis, input logic bus);
    check({tag, "_cycle"}, 32'(res_cycle), 32'(cyc));
    check({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
    check({tag, "_err"}, {30'd0, res_mis, res_bus}, {30'd0, mis, bus});
  endtask

  // ---------------- directed vectors ----------------
  logic [2:0]  ld_f3[5]   = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
  logic [31:0] ld_addr[5] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002,
                              32'h1000_0000, 32'h1000_0001};
  logic [31:0] ld_exp[5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AB,
                              32'h0000_CDEF, 32'hFFFF_FFCD};

  logic [2:0]  st_f3[4]   = '{3'd0, 3'd2, 3'd1, 3'd0};
  logic [31:0] st_addr[4] = '{32'h2000_0001, 32'h2000_0004, 32'h2000_0000, 32'h2000_0003};
  logic [31:0] st_wd[4]   = '{32'hFFFF_FFA5, 32'hDEAD_BEEF, 32'hABCD_5678, 32'h0000_005A};
  logic [31:0] st_awa[4]  = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0000, 32'h2000_0000};
  logic [31:0] st_exd[4]  = '{32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h5678_5678, 32'h5A5A_5A5A};
  logic [3:0]  st_exs[4]  = '{4'b0010, 4'b1111, 4'b0011, 4'b1000};

  logic        ms_wr[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0]  ms_f3[6]   = '{3'd2, 3'd3, 3'd1, 3'd6, 3'd2, 3'd4};
  logic [31:0] ms_addr[6] = '{32'h1000_0002, 32'h1000_0000, 32'h1000_0001,
                              32'h1000_0000, 32'h1000_0002, 32'h1000_0000};

  initial begin
    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_r_valid_ready", {30'd0, arvalid, rready}, 32'd0);
    check("rst_aw_w_b", {29'd0, awvalid, wvalid, bready}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result_data", result_data, 32'd0);
    check("rst_result_rd_err", {25'd0, result_rd, err_misalign, err_bus}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rstn = 1'b1;

    // LW, zero-wait slave
    rdata_cfg = 32'h8765_4321;
    exp_q.push_back(32'h8765_4321);
    do_req("lw", 1'b0, 3'd2, 32'h1000_0008, 32'd0, 5'd5, -1);
    check_done("lw", 3, 5'd5, 1'b0, 1'b0);
    check("lw_araddr", seen_araddr, 32'h1000_0008);
    check("lw_mem_wait", {28'd0, wait_mask[3:0]}, 32'h7);
    check("lw_ar_beats", 32'(ar_cycles), 32'd1);
    check("ar_tieoff", {15'd0, arlen, arsize, arburst, arcache},
          {15'd0, 8'h00, 3'b010, 2'b01, 4'b0011});
    check("aw_tieoff", {15'd0, awlen, awsize, awburst, awcache},
          {15'd0, 8'h00, 3'b010, 2'b01, 4'b0011});

    // load extraction / extension
    rdata_cfg = 32'h80AB_CDEF;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ld_exp[i]);
      do_req("ld_ext", 1'b0, ld_f3[i], ld_addr[i], 32'd0, 5'(i + 10), -1);
      check_done("ld_ext", 3, 5'(i + 10), 1'b0, 1'b0);
    end

    // SH with AWREADY 3 cycles late, WREADY immediate
    aw_wait = 3;
    exp_q.push_back(32'd0);
    do_req("sh", 1'b1, 3'd1, 32'h2000_0002, 32'h0000_1234, 5'd7, -1);
    check_done("sh", 6, 5'd0, 1'b0, 1'b0);
    check("sh_awaddr", seen_awaddr, 32'h2000_0000);
    check("sh_wstrb", {28'd0, seen_wstrb}, 32'hC);
    check("sh_wdata", seen_wdata, 32'h1234_1234);
    check("sh_wlast", {31'd0, seen_wlast}, 32'd1);
    check("sh_wvalid_cycles", 32'(w_cycles), 32'd1);
    check("sh_awvalid_cycles", 32'(aw_cycles), 32'd4);
    aw_wait = 0;

    // stores with WREADY one cycle late
    w_wait = 1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'd0);
      do_req("st", 1'b1, st_f3[i], st_addr[i], st_wd[i], 5'd3, -1);
      check_done("st", 4, 5'd0, 1'b0, 1'b0);
      check("st_awaddr", seen_awaddr, st_awa[i]);
      check("st_wdata", seen_wdata, st_exd[i]);
      check("st_wstrb", {28'd0, seen_wstrb}, {28'd0, st_exs[i]});
      check("st_beats", 32'(aw_cycles * 16 + w_cycles), 32'h12);
    end
    w_wait = 0;

    // misaligned / illegal funct3
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd0);
      do_req("mis", ms_wr[i], ms_f3[i], ms_addr[i], 32'hFFFF_FFFF, 5'(20 + i), -1);
      check_done("mis", 1, ms_wr[i] ? 5'd0 : 5'(20 + i), 1'b1, 1'b0);
      check("mis_bus_activity", 32'(ar_cycles + aw_cycles + w_cycles), 32'd0);
    end

    // bus errors
    resp_cfg = 2'b10;
    exp_q.push_back(32'd0);
    do_req("sw_berr", 1'b1, 3'd2, 32'h2000_0008, 32'h0000_0001, 5'd2, -1);
    check_done("sw_berr", 3, 5'd0, 1'b0, 1'b1);
    rdata_cfg = 32'h1234_5678;
    exp_q.push_back(32'd0);
    do_req("lw_rerr", 1'b0, 3'd2, 32'h1000_0000, 32'd0, 5'd6, -1);
    check_done("lw_rerr", 3, 5'd6, 1'b0, 1'b1);
    resp_cfg = 2'b00;

    // slow slave: ARREADY 2 late, RVALID 1 late
    ar_wait = 2; r_wait = 1;
    rdata_cfg = 32'hCAFE_0042;
    exp_q.push_back(32'hCAFE_0042);
    do_req("lw_slow", 1'b0, 3'd2, 32'h1000_0040, 32'd0, 5'd8, -1);
    check_done("lw_slow", 6, 5'd8, 1'b0, 1'b0);
    ar_wait = 0;

    // reset while waiting in R
    r_wait = 5;
    do_req("rst_mid", 1'b0, 3'd2, 32'h1000_0010, 32'd0, 5'd3, 2);
    check("rst_mid_bus_idle", {26'd0, post_rst_bus}, 32'd0);
    check("rst_mid_no_result", 32'(rv_after_rst), 32'd0);
    r_wait = 0;
    rdata_cfg = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    do_req("lw_after_rst", 1'b0, 3'd2, 32'h1000_0014, 32'd0, 5'd4, -1);
    check_done("lw_after_rst", 3, 5'd4, 1'b0, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_access.md
# data_access

Data-memory access stage of the RV32I core. Sits downstream of execute and upstream of write-back. It takes one load/store request per instruction, performs a single-beat AXI4 read or write on the core's data port, and aligns and sign-extends load data. While a request is outstanding it raises `MEM_WAIT`, which the core ORs into its global `stall` alongside the instruction-fetch wait.

## Interface
Parameters:
- `C_M_AXI_THREAD_ID_WIDTH`, 1: width of AWID/ARID/BID/RID.
- `C_M_AXI_ADDR_WIDTH`, 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.

Ports:
- `CLK`  in  1: single clock; all logic on the rising edge.
- `RSTN`  in  1: reset, synchronous, active-low.
- `REQ_VALID`  in  1: a load/store is presented. Held stable by upstream while `MEM_WAIT`=1.
- `REQ_WRITE`  in  1: 1 = store, 0 = load.
- `REQ_FUNCT3`  in  3: RV32I funct3. Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores: SB=0, SH=1, SW=2.
- `REQ_ADDR`  in  32: byte address (rs1+imm).
- `REQ_WDATA`  in  32: store data (rs2), LSB-justified.
- `REQ_RD`  in  5: load destination register.
- `MEM_WAIT`  out  1: stall request to the core.
- `RESULT_VALID`  out  1: one-cycle completion pulse.
- `RESULT_RD`  out  5: destination register for loads; 0 for stores.
- `RESULT_DATA`  out  32: extended load data; 0 for stores and errors.
- `ERR_MISALIGN`  out  1: with `RESULT_VALID`, marks a misaligned or illegal funct3 request.
- `ERR_BUS`  out  1: with `RESULT_VALID`, marks RRESP/BRESP ≠ 0.
- `M_AXI_AW*`, `M_AXI_W*`, `M_AXI_B*`, `M_AXI_AR*`, `M_AXI_R*`: full AXI4 master ports. Tie-offs:
  - LEN=0, SIZE=3'b010, BURST=INCR, LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, USER=0, ID=0.
  - WLAST=1 whenever WVALID=1.

## Operation
FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE with REQ_VALID=1:
  - If the request is legal and aligned, latch it and go to AR (load) or AW_W (store).
  - Otherwise go to DONE with misalign=1 and no bus traffic.
- Legality and alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Load funct3 3/6/7 and store funct3 3..7 are illegal (flagged as misalign).
- AR: ARVALID=1, ARADDR={addr[31:2],2'b00}. On ARREADY go to R.
- R: RREADY=1. On RVALID, capture the extended data and RRESP, then go to DONE.
- AW_W: AWVALID and WVALID are both asserted. Each is dropped independently once its own handshake completes. Go to B once both have completed, including the case where they complete in the same cycle.
- B: BREADY=1. On BVALID, capture BRESP and go to DONE.
- DONE: RESULT_VALID=1, MEM_WAIT=0, then go to IDLE. No new request is accepted in DONE.
- MEM_WAIT = REQ_VALID && state≠DONE. This is combinational, so it is high in the acceptance cycle.
- WSTRB and WDATA:
  - SB: strobe = 1<<addr[1:0]; byte replicated on all 4 lanes.
  - SH: strobe = 4'b0011<<addr[1:0] (addr[1]=0 → 0011, addr[1]=1 → 1100); half replicated on both halves.
  - SW: strobe = 1111; data as-is.
- Load extraction:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: word as-is.
- On RESP≠0, RESULT_DATA=0 and ERR_BUS=1.

## Timing
- Reset values: all AXI VALID/READY = 0, RESULT_VALID=0, RESULT_RD=0, RESULT_DATA=0, ERR_*=0, state IDLE.
- Reset mid-transaction returns to IDLE in the same edge, with no completion pulse. The interconnect is reset alongside the core.
- Load latency with zero-wait slave:
  - Cycle 0: accept.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: RESULT_VALID.
  - Total 4 cycles; one extra cycle per ARREADY or RVALID wait cycle.
- Store latency: the same 4 cycles (AW/W in cycle 1, B in cycle 2).
- Misaligned request: RESULT_VALID in cycle 1.
- Back-to-back: a new request is accepted at the earliest the cycle after DONE.
- Outputs RESULT_* and ERR_* are registered; they are valid only while RESULT_VALID=1 and held otherwise.
- Each AXI VALID stays high until its READY and never depends on READY.
- ADDR/DATA/STRB are stable while VALID is high.

## Test plan
- LW at 0x1000_0008, slave returns 0x8765_4321 with ARREADY/RVALID immediate:
  - ARADDR=0x1000_0008.
  - RESULT_VALID in cycle 3, RESULT_DATA=0x8765_4321, RESULT_RD as given.
  - MEM_WAIT high in cycles 0–2.
- LB and LBU at 0x...0003 with RDATA=0x80AB_CDEF: RESULT_DATA=0xFFFF_FF80 and 0x0000_0080. LH at 0x...0002 gives 0xFFFF_80AB.
- SH at 0x...0002 with WDATA=0x0000_1234:
  - AWADDR=0x...0000, WSTRB=1100, WDATA=0x1234_1234, WLAST=1.
  - AWREADY delayed 3 cycles and WREADY immediate: WVALID drops after 1 cycle, AWVALID holds until accepted.
- LW at 0x...0002 and SB with funct3=3: no AR/AW activity; RESULT_VALID in cycle 1 with ERR_MISALIGN=1 and RESULT_DATA=0.
- SW with BRESP=2'b10 → ERR_BUS=1. LW with RRESP=SLVERR → ERR_BUS=1 and RESULT_DATA=0.
- RSTN low for one cycle while in R: all VALID/READY=0 next cycle and no RESULT_VALID. A fresh LW then completes normally.
